inst_encoder: RTL and testbench

Registered RISC-V instruction encoder: accepts decoded fields (operation, register indices, signed immediate) over a valid/ready handshake. It emits the packed 32-bit instruction word and an auto-incrementing word address, so test programs and boot images can be written into instruction memory. It is the encode-side counterpart of the CPU's immediate-generation and decode logic, and covers the same instruction subset. Output is a one-entry pipeline register with backpressure.

---
 rtl/inst_encoder_pkg.sv | 46 ++++
 rtl/inst_pack.sv | 60 ++++++
 rtl/inst_encoder.sv | 82 ++++++++
 tb/tb_inst_encoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared encoder definitions: op enum, RV32 opcode/funct fields, NOP word and immediate limits.
// Used by inst_pack and inst_encoder.
package enc_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_XOR  = 4'd1,
      OP_SLL  = 4'd2,
      OP_ADD  = 4'd3,
      OP_SUB  = 4'd4,
      OP_MUL  = 4'd5,
      OP_ADDI = 4'd6,
      OP_SRAI = 4'd7,
      OP_LW   = 4'd8,
      OP_SW   = 4'd9,
      OP_BEQ  = 4'd10
   } op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SRA  = 3'b101;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [31:0] NOP = 32'h00000013;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int SHAMT_MIN = 0;
   localparam int SHAMT_MAX = 31;
   localparam int BR_MIN    = -4096;
   localparam int BR_MAX    = 4094;

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: op + register indices + immediate -> RV32 word, plus range error.
// Range checking is present only when ENC_RANGE_CHECK_EN is defined; otherwise err is 0.
module inst_pack
   import enc_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        err
);

   always_comb begin
      word = NOP;
      case (op)
         OP_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
         OP_XOR:  word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_OP};
         OP_SLL:  word = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_OP};
         OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
         OP_SUB:  word = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPC_OP};
         OP_MUL:  word = {F7_MUL,  rs2, rs1, F3_ADD, rd, OPC_OP};
         OP_ADDI: word = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
         OP_SRAI: word = {F7_ALT, imm[4:0], rs1, F3_SRA, rd, OPC_OP_IMM};
         OP_LW:   word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
         OP_SW:   word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
         // B-type scatters imm[12:1]; imm[0] is implicitly zero and dropped
         OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                          imm[4:1], imm[11], OPC_BRANCH};
         default: word = NOP;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic signed [31:0] simm;
   assign simm = imm;

   always_comb begin
      err = 1'b0;
      case (op)
         OP_AND, OP_XOR, OP_SLL, OP_ADD, OP_SUB, OP_MUL:
            err = 1'b0;
         OP_ADDI, OP_LW, OP_SW:
            err = (simm < IMM12_MIN) || (simm > IMM12_MAX);
         OP_SRAI:
            err = (simm < SHAMT_MIN) || (simm > SHAMT_MAX);
         OP_BEQ:
            err = (simm < BR_MIN) || (simm > BR_MAX) || imm[0];
         default:
            err = 1'b1;
      endcase
   end
`else
   logic unused_imm;
   assign unused_imm = ^imm[31:13];
   assign err = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Registered RISC-V instruction encoder: valid/ready input, one-entry output register,
// auto-incrementing word address. Optional immediate range checking via ENC_RANGE_CHECK_EN.
module inst_encoder
   import enc_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        op_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [31:0]       imm_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [31:0]       data_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              err_o
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e            state, state_nxt;
   logic              accept;
   logic [ADDR_W-1:0] cnt;
   logic [31:0]       pack_word;
   logic              pack_err;

   inst_pack u_pack (
      .op   (op_i),
      .rd   (rd_i),
      .rs1  (rs1_i),
      .rs2  (rs2_i),
      .imm  (imm_i),
      .word (pack_word),
      .err  (pack_err)
   );

   assign valid_o = (state == FULL);
   assign ready_o = !valid_o || ready_i;
   assign accept  = valid_i && ready_o;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (ready_i && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= EMPTY;
         data_o <= '0;
         addr_o <= '0;
         err_o  <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            data_o <= pack_word;
            err_o  <= pack_err;
            // clear in the accept cycle hands out address 0 and leaves 1 for the next word
            if (clear_i) begin
               addr_o <= '0;
               cnt    <= ADDR_W'(1);
            end else begin
               addr_o <= cnt;
               cnt    <= cnt + ADDR_W'(1);
            end
         end else if (clear_i) begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (ADDR_W=2 to exercise address wrap).
// Expected err_o depends on whether ENC_RANGE_CHECK_EN is defined.
module tb_inst_encoder;
   import enc_pkg::*;

   localparam int unsigned AW = 2;

`ifdef ENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, clear, valid_in, ready_out, valid_out, ready_in, err;
   logic [3:0]    op;
   logic [4:0]    rd, rs1, rs2;
   logic [31:0]   imm, data;
   logic [AW-1:0] addr;

   int n_assert = 0;
   int n_fail   = 0;

   inst_encoder #(.ADDR_W(AW)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .valid_i (valid_in),
      .ready_o (ready_out),
      .op_i    (op),
      .rd_i    (rd),
      .rs1_i   (rs1),
      .rs2_i   (rs2),
      .imm_i   (imm),
      .valid_o (valid_out),
      .ready_i (ready_in),
      .data_o  (data),
      .addr_o  (addr),
      .err_o   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fields(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
      op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
   endtask

   // table of single-word encodings: op, rd, rs1, rs2, imm, expected word, err under range check
   typedef struct {
      logic [3:0]  o;
      logic [4:0]  d, s1, s2;
      logic [31:0] im;
      logic [31:0] w;
      logic        e;
   } vec_t;

   vec_t vecs [9];
   int unsigned exp_addr [7];

   initial begin
      vecs[0] = '{4'd6,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, 1'b1};
      vecs[1] = '{4'd7,  5'd1, 5'd2, 5'd0, 32'd3,        32'h40315093, 1'b0};
      vecs[2] = '{4'd7,  5'd1, 5'd2, 5'd0, 32'd32,       32'h40015093, 1'b1};
      vecs[3] = '{4'd10, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b1};
      vecs[4] = '{4'd8,  5'd2, 5'd3, 5'd0, 32'hFFFFF800, 32'h8001A103, 1'b0};
      vecs[5] = '{4'd12, 5'd1, 5'd1, 5'd1, 32'd0,        32'h00000013, 1'b1};
      vecs[6] = '{4'd5,  5'd1, 5'd2, 5'd3, 32'd0,        32'h023100B3, 1'b0};
      vecs[7] = '{4'd0,  5'd4, 5'd5, 5'd6, 32'd0,        32'h0062F233, 1'b0};
      vecs[8] = '{4'd2,  5'd1, 5'd1, 5'd1, 32'd0,        32'h001090B3, 1'b0};
      exp_addr = '{0, 1, 2, 3, 0, 0, 1};

      rst = 1'b1; clear = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      fields(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("reset valid_o", 32'(valid_out), 32'd0);
      chk("reset data_o",  data,           32'd0);
      chk("reset addr_o",  32'(addr),      32'd0);
      chk("reset err_o",   32'(err),       32'd0);
      chk("reset ready_o", 32'(ready_out), 32'd1);

      // first ADDI after reset
      fields(4'd6, 5'd1, 5'd0, 5'd0, 32'd5); valid_in = 1'b1;
      @(negedge clk);
      chk("addi valid_o", 32'(valid_out), 32'd1);
      chk("addi data_o",  data,           32'h00500093);
      chk("addi addr_o",  32'(addr),      32'd0);
      chk("addi err_o",   32'(err),       32'd0);

      // clear alone, then three back-to-back words
      valid_in = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("drain valid_o", 32'(valid_out), 32'd0);
      fields(4'd4, 5'd3, 5'd1, 5'd2, 32'd0); valid_in = 1'b1;
      @(negedge clk);
      chk("sub data_o", data, 32'h402081B3);
      chk("sub addr_o", 32'(addr), 32'd0);
      fields(4'd9, 5'd0, 5'd0, 5'd2, 32'd8);
      @(negedge clk);
      chk("sw data_o", data, 32'h00202423);
      chk("sw addr_o", 32'(addr), 32'd1);
      chk("sw valid_o", 32'(valid_out), 32'd1);
      fields(4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
      @(negedge clk);
      chk("beq data_o", data, 32'hFE208EE3);
      chk("beq addr_o", 32'(addr), 32'd2);
      chk("beq err_o",  32'(err), 32'd0);
      valid_in = 1'b0;
      @(negedge clk);
      chk("idle valid_o", 32'(valid_out), 32'd0);

      // backpressure: word A held two cycles, clear during hold must not touch it
      ready_in = 1'b0;
      fields(4'd3, 5'd5, 5'd6, 5'd7, 32'd0); valid_in = 1'b1;
      @(negedge clk);
      chk("bp A data_o",  data, 32'h007302B3);
      chk("bp A addr_o",  32'(addr), 32'd3);
      chk("bp ready_o 1", 32'(ready_out), 32'd0);
      fields(4'd1, 5'd8, 5'd9, 5'd10, 32'd0); clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("bp hold data_o", data, 32'h007302B3);
      chk("bp hold addr_o", 32'(addr), 32'd3);
      @(negedge clk);
      chk("bp hold2 data_o", data, 32'h007302B3);
      chk("bp ready_o 2",    32'(ready_out), 32'd0);
      chk("bp valid_o",      32'(valid_out), 32'd1);
      ready_in = 1'b1;
      #1;
      chk("bp ready_o back", 32'(ready_out), 32'd1);
      @(negedge clk);
      chk("bp B data_o", data, 32'h00A4C433);
      chk("bp B addr_o", 32'(addr), 32'd0);
      valid_in = 1'b0;
      @(negedge clk);
      chk("bp no dup valid_o", 32'(valid_out), 32'd0);

      // address wrap with ADDR_W=2, then clear coinciding with accept
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      valid_in = 1'b1;
      for (int i = 0; i < 7; i++) begin
         fields(4'd6, 5'(i + 1), 5'd0, 5'd0, 32'(i));
         clear = (i == 5);
         @(negedge clk);
         chk($sformatf("wrap%0d addr_o", i), 32'(addr), 32'(exp_addr[i]));
         chk($sformatf("wrap%0d data_o", i), data,
             {20'(i), 5'd0, 3'b000, 5'(i + 1), 7'h13});
      end
      clear = 1'b0;

      // encodings and range errors
      for (int i = 0; i < 9; i++) begin
         fields(vecs[i].o, vecs[i].d, vecs[i].s1, vecs[i].s2, vecs[i].im);
         @(negedge clk);
         chk($sformatf("vec%0d data_o", i), data, vecs[i].w);
         chk($sformatf("vec%0d err_o", i), 32'(err), 32'(vecs[i].e & RC));
      end
      valid_in = 1'b0;
      @(negedge clk);

      // reset while FULL and stalled
      ready_in = 1'b0;
      fields(4'd6, 5'd2, 5'd0, 5'd0, 32'd7); valid_in = 1'b1;
      @(negedge clk);
      chk("rst pre valid_o", 32'(valid_out), 32'd1);
      rst = 1'b1; valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst valid_o", 32'(valid_out), 32'd0);
      chk("rst addr_o",  32'(addr),      32'd0);
      ready_in = 1'b1; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk("post rst addr_o", 32'(addr), 32'd0);
      chk("post rst data_o", data, 32'h00700113);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
